panel_streamer: RTL and testbench

Parametrised successor to the board's fixed seg/LED readout path. It snapshots `NUM_CH` 16-bit display/status channels into a frame and streams the frame, one beat per host strobe edge, to the Raspberry Pi host. Each frame is a header beat carrying a sequence number, then the payload, MSB first, then an optional XOR check beat. It sits beside `Display`/`GPIO` in the board top and takes their shadow data (e.g. `seg64`, `led16`) as `ch_data`.

---
 rtl/panel_stream_pkg.sv | 23 ++
 rtl/panel_streamer_strobe_sync.sv | 23 ++
 rtl/panel_streamer.sv | 156 +++++++++++++++
 tb/tb_panel_streamer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_stream_pkg.sv
// Shared types and helpers for the panel streamer: FSM state encoding,
// default geometry, start-of-frame flag position and beat-counter sizing.
package panel_stream_pkg;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_HEADER,
    PS_PAYLOAD,
    PS_CHECK
  } ps_state_t;

  localparam int PS_NUM_CH = 5;
  localparam int PS_CH_W   = 16;
  localparam int PS_DATA_W = 4;

  // The flag sits directly above the payload bits of a beat.
  localparam int PS_SOF_BIT = PS_DATA_W;

  function automatic int ps_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/panel_streamer_strobe_sync.sv
// 2-FF synchroniser plus rising-edge detector; turns an asynchronous strobe
// (host_clk, SegLedClk, ps2_clk style inputs) into a one-cycle pulse.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // [0],[1] synchroniser stages, [2] previous value of the synchronised strobe
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/panel_streamer.sv
// Snapshots NUM_CH channels and streams header/payload(/check) beats, one per host strobe.
// Optional XOR check beat compiled in with PANEL_STREAM_CHECK_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// PS_IDLE    | no frame; dout = 0, busy = 0, waiting for strobe with stream_en
// PS_HEADER  | header beat {1, seq} on dout, snapshot frozen
// PS_PAYLOAD | payload beat idx on dout, MSB nibble first
// PS_CHECK   | XOR of all payload nibbles on dout (check build only)
module panel_streamer
  import panel_stream_pkg::*;
#(
  parameter int NUM_CH = PS_NUM_CH,
  parameter int CH_W   = PS_CH_W,
  parameter int DATA_W = PS_DATA_W
) (
  input  logic                     clk_100mhz,
  input  logic                     rst,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic                     stream_en,
  input  logic                     host_clk,
  output logic [DATA_W:0]          dout,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int BEATS = NUM_CH * CH_W / DATA_W;
  localparam int CNT_W = ps_cnt_w(BEATS);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_IDX = cnt_t'(BEATS - 1);

  if ((NUM_CH * CH_W) % DATA_W != 0) begin : g_width_check
    $error("panel_streamer: NUM_CH*CH_W must be a multiple of DATA_W");
  end

  logic adv;

  strobe_sync u_strobe_sync (
    .clk   (clk_100mhz),
    .rst   (rst),
    .din   (host_clk),
    .pulse (adv)
  );

  ps_state_t                      state, state_nxt;
  cnt_t                           idx, idx_nxt;
  logic [DATA_W-1:0]              seq, seq_nxt;
  logic [BEATS-1:0][DATA_W-1:0]   snap, snap_nxt;
  logic [DATA_W:0]                dout_nxt;
  logic                           done_nxt;
  logic                           start_frame;
  logic                           load_beat;
  cnt_t                           load_idx;
  logic [DATA_W-1:0]              nib;
`ifdef PANEL_STREAM_CHECK_EN
  logic [DATA_W-1:0]              acc, acc_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    seq_nxt     = seq;
    snap_nxt    = snap;
    dout_nxt    = dout;
    done_nxt    = 1'b0;
    start_frame = 1'b0;
    load_beat   = 1'b0;
    load_idx    = '0;
    nib         = '0;
`ifdef PANEL_STREAM_CHECK_EN
    acc_nxt     = acc;
`endif

    // Dropping stream_en overrides a coincident strobe.
    if (!stream_en) begin
      state_nxt = PS_IDLE;
      idx_nxt   = '0;
      dout_nxt  = '0;
    end else if (adv) begin
      unique case (state)
        PS_IDLE:   start_frame = 1'b1;
        PS_HEADER: load_beat   = 1'b1;
        PS_PAYLOAD: begin
          if (idx != LAST_IDX) begin
            load_beat = 1'b1;
            load_idx  = idx + 1'b1;
          end else begin
`ifdef PANEL_STREAM_CHECK_EN
            state_nxt = PS_CHECK;
            dout_nxt  = {1'b0, acc};
            done_nxt  = 1'b1;
`else
            start_frame = 1'b1;
            seq_nxt     = seq + 1'b1;
`endif
          end
        end
        PS_CHECK: begin
          start_frame = 1'b1;
          seq_nxt     = seq + 1'b1;
        end
        default: state_nxt = PS_IDLE;
      endcase
    end

    if (start_frame) begin
      snap_nxt  = ch_data;
      dout_nxt  = {1'b1, seq_nxt};
      state_nxt = PS_HEADER;
      idx_nxt   = '0;
`ifdef PANEL_STREAM_CHECK_EN
      acc_nxt   = '0;
`endif
    end

    if (load_beat) begin
      nib       = snap[LAST_IDX - load_idx];
      idx_nxt   = load_idx;
      dout_nxt  = {1'b0, nib};
      state_nxt = PS_PAYLOAD;
`ifdef PANEL_STREAM_CHECK_EN
      acc_nxt   = acc ^ nib;
`else
      done_nxt  = (load_idx == LAST_IDX);
`endif
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state      <= PS_IDLE;
      idx        <= '0;
      seq        <= '0;
      snap       <= '0;
      dout       <= '0;
      frame_done <= 1'b0;
`ifdef PANEL_STREAM_CHECK_EN
      acc        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      seq        <= seq_nxt;
      snap       <= snap_nxt;
      dout       <= dout_nxt;
      frame_done <= done_nxt;
`ifdef PANEL_STREAM_CHECK_EN
      acc        <= acc_nxt;
`endif
    end
  end

  assign busy = (state != PS_IDLE);

endmodule

// File: tb/tb_panel_streamer.sv
// Directed self-checking bench for panel_streamer (NUM_CH=5, CH_W=16, DATA_W=4).
// Expectations follow PANEL_STREAM_CHECK_EN when it is defined.
module tb_panel_streamer;
  import panel_stream_pkg::*;

  localparam int BEATS = 20;
`ifdef PANEL_STREAM_CHECK_EN
  localparam int FRAME_LEN = BEATS + 2;
`else
  localparam int FRAME_LEN = BEATS + 1;
`endif

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] ch_data = '0;
  logic        stream_en = 1'b0;
  logic        host_clk = 1'b0;
  logic [4:0]  dout;
  logic        busy;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [4:0]  done_beat = '0;
  logic [3:0]  exp_seq = '0;

  panel_streamer #(.NUM_CH(5), .CH_W(16), .DATA_W(4)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .ch_data    (ch_data),
    .stream_en  (stream_en),
    .host_clk   (host_clk),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(negedge clk_100mhz) begin
    if (frame_done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_beat = dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] exp_nib(input logic [79:0] d, input int k);
    logic [79:0] s;
    s = d >> ((BEATS - 1 - k) * 4);
    return s[3:0];
  endfunction

  // One host beat: 6 cycles high, 6 cycles low; dout is settled at return.
  task automatic strobe();
    host_clk = 1'b1;
    repeat (6) @(negedge clk_100mhz);
    host_clk = 1'b0;
    repeat (6) @(negedge clk_100mhz);
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz);
    rst = 1'b1;
    stream_en = 1'b0;
    host_clk = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    rst = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    exp_seq = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stream_en = 1'b0;
    host_clk = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_100mhz);
      checks++;
      if (dout !== 5'h00) begin
        errors++;
        $display("FAIL reset_dout cycle %0d: got %h expected 00", c, dout);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy cycle %0d: got %b expected 0", c, busy);
      end
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_frame_done cycle %0d: got %b expected 0", c, frame_done);
      end
      if (c < 2) host_clk = ~host_clk;
      if (c == 1) rst = 1'b0;
    end
    host_clk = 1'b0;
    repeat (4) @(negedge clk_100mhz);
  endtask

  task automatic test_basic_frame();
    logic [4:0] e;
    ch_data   = 80'h0000_0000_0000_0000_00A5;
    stream_en = 1'b1;
    done_cnt  = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      strobe();
      if (i == 0)       e = 5'h10;
      else if (i <= 18) e = 5'h00;
      else if (i == 19) e = 5'h0A;
      else if (i == 20) e = 5'h05;
      else              e = 5'h0F;
      checks++;
      if (dout !== e) begin
        errors++;
        $display("FAIL basic_beat %0d: got %h expected %h", i, dout, e);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy %0d: got %b expected 1", i, busy);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
`ifdef PANEL_STREAM_CHECK_EN
    e = 5'h0F;
`else
    e = 5'h05;
`endif
    checks++;
    if (done_beat !== e) begin
      errors++;
      $display("FAIL basic_done_beat: got %h expected %h", done_beat, e);
    end
    strobe();
    checks++;
    if (dout !== 5'h11) begin
      errors++;
      $display("FAIL basic_next_header: got %h expected 11", dout);
    end
    exp_seq = 4'h1;
    stream_en = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_latency_freeze();
    logic [79:0] snap_val;
    int lat;
    snap_val  = 80'h0123_4567_89AB_CDEF_FEDC;
    ch_data   = snap_val;
    stream_en = 1'b1;
    @(negedge clk_100mhz);
    host_clk = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk_100mhz);
      if (dout !== 5'h00) lat = c;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 3", lat);
    end
    checks++;
    if (dout !== {1'b1, exp_seq}) begin
      errors++;
      $display("FAIL latency_header: got %h expected %h", dout, {1'b1, exp_seq});
    end
    repeat (6) @(negedge clk_100mhz);
    host_clk = 1'b0;
    ch_data = ~snap_val;
    repeat (6) @(negedge clk_100mhz);
    for (int k = 0; k < BEATS; k++) begin
      strobe();
      checks++;
      if (dout !== {1'b0, exp_nib(snap_val, k)}) begin
        errors++;
        $display("FAIL freeze_beat %0d: got %h expected %h", k, dout, {1'b0, exp_nib(snap_val, k)});
      end
    end
    stream_en = 1'b0;
    repeat (2) @(negedge clk_100mhz);
  endtask

  task automatic test_abort();
    do_reset();
    ch_data   = 80'h0000_0000_0000_0000_00A5;
    stream_en = 1'b1;
    done_cnt  = 0;
    for (int i = 0; i < 7; i++) strobe();
    stream_en = 1'b0;
    @(negedge clk_100mhz);
    checks++;
    if (dout !== 5'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got dout %h busy %b expected 00 0", dout, busy);
    end
    stream_en = 1'b1;
    strobe();
    checks++;
    if (dout !== 5'h10) begin
      errors++;
      $display("FAIL abort_reheader: got %h expected 10", dout);
    end
    strobe();
    // strobe pulse lands in the same cycle stream_en falls
    host_clk = 1'b1;
    repeat (2) @(negedge clk_100mhz);
    stream_en = 1'b0;
    @(negedge clk_100mhz);
    checks++;
    if (dout !== 5'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_coincident: got dout %h busy %b expected 00 0", dout, busy);
    end
    repeat (4) @(negedge clk_100mhz);
    host_clk = 1'b0;
    repeat (6) @(negedge clk_100mhz);
    stream_en = 1'b1;
    strobe();
    checks++;
    if (dout !== 5'h10) begin
      errors++;
      $display("FAIL abort_seq_kept: got %h expected 10", dout);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt);
    end
    stream_en = 1'b0;
    repeat (2) @(negedge clk_100mhz);
  endtask

  task automatic test_seq_wrap();
    logic [3:0] fs;
    do_reset();
    ch_data   = 80'h1111_2222_3333_4444_5555;
    stream_en = 1'b1;
    done_cnt  = 0;
    for (int f = 0; f < 17; f++) begin
      fs = f[3:0];
      strobe();
      checks++;
      if (dout !== {1'b1, fs}) begin
        errors++;
        $display("FAIL wrap_header frame %0d: got %h expected %h", f, dout, {1'b1, fs});
      end
      if (f < 16) begin
        for (int b = 1; b < FRAME_LEN; b++) strobe();
      end
    end
    checks++;
    if (done_cnt != 16) begin
      errors++;
      $display("FAIL wrap_done_count: got %0d expected 16", done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int b = 1; b < FRAME_LEN; b++) strobe();
    strobe();
    checks++;
    if (dout !== 5'h11) begin
      errors++;
      $display("FAIL rst_pre_header: got %h expected 11", dout);
    end
    strobe();
    strobe();
    rst = 1'b1;
    @(negedge clk_100mhz);
    checks++;
    if (dout !== 5'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_frame: got dout %h busy %b done %b expected 00 0 0", dout, busy, frame_done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk_100mhz);
    strobe();
    checks++;
    if (dout !== 5'h10) begin
      errors++;
      $display("FAIL rst_seq_cleared: got %h expected 10", dout);
    end
    checks++;
    if (dout[PS_SOF_BIT] !== 1'b1) begin
      errors++;
      $display("FAIL rst_sof_flag: got %b expected 1", dout[PS_SOF_BIT]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency_freeze();
    test_abort();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
